// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM frame capture with duty recovery; PWM_CAPTURE_VOLDIV_EN adds the divide-by-VOL stage
// Frames start on a rising edge of the synchronized input and are 2**FRAME_BITS clocks long.
module pwm_capture #(
  parameter int FRAME_BITS = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       P_IN,
  input  logic [3:0] VOL,
  output logic [7:0] SAMPLE,
  output logic       VALID,
  output logic       LOCKED,
  output logic       SAT
);

  localparam logic [FRAME_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {HUNT, TRACK} state_t;
  state_t state;

  logic sync1, ps, ps_d, rise;
  logic [FRAME_BITS-1:0] frame_cnt, high_cnt, high_next;
  logic edge_seen, frame_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      ps    <= 1'b0;
      ps_d  <= 1'b0;
    end else begin
      sync1 <= P_IN;
      ps    <= sync1;
      ps_d  <= ps;
    end
  end

  assign rise      = ps & ~ps_d;
  assign high_next = (ps && high_cnt != CNT_MAX) ? high_cnt + 1'b1 : high_cnt;
  // Only frames that began with an edge at position 0 deliver a sample.
  assign frame_end = (state == TRACK) && !rise && (frame_cnt == CNT_MAX) && edge_seen;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HUNT;
      LOCKED    <= 1'b0;
      frame_cnt <= '0;
      high_cnt  <= '0;
      edge_seen <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (rise) begin
            state     <= TRACK;
            LOCKED    <= 1'b1;
            frame_cnt <= FRAME_BITS'(1);
            high_cnt  <= FRAME_BITS'(1);
            edge_seen <= 1'b1;
          end
        end
        TRACK: begin
          if (rise && frame_cnt != '0) begin
            frame_cnt <= FRAME_BITS'(1);
            high_cnt  <= FRAME_BITS'(1);
            edge_seen <= 1'b1;
          end else if (frame_cnt == CNT_MAX) begin
            frame_cnt <= '0;
            high_cnt  <= '0;
            edge_seen <= 1'b0;
            if (!edge_seen) begin
              state  <= HUNT;
              LOCKED <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            high_cnt  <= high_next;
            if (rise) edge_seen <= 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

`ifdef PWM_CAPTURE_VOLDIV_EN
  localparam int STEP_W = $clog2(FRAME_BITS + 1);

  logic                  busy, vol_zero, q_bit;
  logic [STEP_W-1:0]     step;
  logic [3:0]            divisor, rem, r_sub;
  logic [4:0]            r_sh;
  logic [FRAME_BITS-1:0] quo, q_next;

  always_comb begin
    r_sh   = {rem, quo[FRAME_BITS-1]};
    q_bit  = (r_sh >= {1'b0, divisor});
    r_sub  = r_sh[3:0] - divisor;
    q_next = {quo[FRAME_BITS-2:0], q_bit};
  end

  // Restoring divide: quo shifts out the dividend and shifts in quotient bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy     <= 1'b0;
      vol_zero <= 1'b0;
      step     <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      SAMPLE   <= '0;
      SAT      <= 1'b0;
      VALID    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (frame_end) begin
        busy     <= 1'b1;
        vol_zero <= (VOL == 4'd0);
        step     <= STEP_W'(FRAME_BITS);
        divisor  <= VOL;
        rem      <= '0;
        quo      <= high_next;
      end else if (busy) begin
        if (!vol_zero) begin
          quo <= q_next;
          rem <= q_bit ? r_sub : r_sh[3:0];
        end
        step <= step - 1'b1;
        if (step == STEP_W'(1)) begin
          busy  <= 1'b0;
          VALID <= 1'b1;
          if (vol_zero) begin
            SAMPLE <= '0;
            SAT    <= 1'b1;
          end else if (q_next[FRAME_BITS-1:8] != '0) begin
            SAMPLE <= 8'hff;
            SAT    <= 1'b1;
          end else begin
            SAMPLE <= q_next[7:0];
            SAT    <= 1'b0;
          end
        end
      end
    end
  end
`else
  logic unused_vol;
  assign unused_vol = ^VOL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      SAMPLE <= '0;
      SAT    <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      VALID <= frame_end;
      SAT   <= 1'b0;
      if (frame_end) SAMPLE <= high_next[FRAME_BITS-1 -: 8];
    end
  end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed bench for pwm_capture (either PWM_CAPTURE_VOLDIV_EN setting)
`timescale 1ns/1ps
module tb_pwm_capture;

`ifdef PWM_CAPTURE_VOLDIV_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       P_IN = 1'b0;
  logic [3:0] VOL = 4'd4;
  logic [7:0] SAMPLE;
  logic       VALID, LOCKED, SAT;

  pwm_capture #(.FRAME_BITS(12)) dut (
    .CLK(CLK), .RST(RST), .P_IN(P_IN), .VOL(VOL),
    .SAMPLE(SAMPLE), .VALID(VALID), .LOCKED(LOCKED), .SAT(SAT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int v_cnt = 0;
  int last_v_cyc = -1;
  logic [7:0] last_sample = '0;
  logic last_sat = 1'b0;
  bit lock_low_seen = 1'b0;
  int gen_mode = 0;
  int gen_high = 0;
  int gen_pos = 0;
  int frame_k = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (VALID === 1'b1) begin
      v_cnt++;
      last_v_cyc = cyc;
      last_sample = SAMPLE;
      last_sat = SAT;
    end
    if (LOCKED !== 1'b1) lock_low_seen = 1'b1;
    case (gen_mode)
      0: P_IN = 1'b0;
      1: P_IN = 1'b1;
      default: begin
        if (gen_pos == 0) frame_k = cyc;
        P_IN = (gen_pos < gen_high);
        gen_pos = (gen_pos + 1) % 4096;
      end
    endcase
  endtask

  task automatic run_until_valid(input int budget);
    int start;
    int n;
    start = v_cnt;
    n = 0;
    while (v_cnt == start && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    gen_mode = 0;
    repeat (3) tick();
    RST = 1'b0;
    v_cnt = 0;
    last_v_cyc = -1;
  endtask

  task automatic start_pwm(input logic [3:0] vol, input int high, output int k0);
    VOL = vol;
    gen_high = high;
    gen_pos = 0;
    gen_mode = 2;
    tick();
    k0 = frame_k;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    vectors++; if (SAMPLE !== 8'd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", SAMPLE); end
    vectors++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", VALID); end
    vectors++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", LOCKED); end
    vectors++; if (SAT !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", SAT); end
  endtask

  task automatic test_nominal();
    int k0;
    logic [7:0] exp_s;
`ifdef PWM_CAPTURE_VOLDIV_EN
    exp_s = 8'd100;
`else
    exp_s = 8'd25;
`endif
    do_reset();
    start_pwm(4'd4, 400, k0);
    repeat (6) tick();
    vectors++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL nom_lock: got %b expected 1", LOCKED); end
    lock_low_seen = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_until_valid(5000);
      vectors++; if (last_v_cyc != k0 + f*4096 + 4097 + LAT) begin errors++; $display("FAIL nom_valid_time%0d: got %0d expected %0d", f, last_v_cyc, k0 + f*4096 + 4097 + LAT); end
      vectors++; if (last_sample !== exp_s) begin errors++; $display("FAIL nom_sample%0d: got %0d expected %0d", f, last_sample, exp_s); end
      vectors++; if (last_sat !== 1'b0) begin errors++; $display("FAIL nom_sat%0d: got %b expected 0", f, last_sat); end
    end
    vectors++; if (v_cnt != 3) begin errors++; $display("FAIL nom_valid_count: got %0d expected 3", v_cnt); end
    vectors++; if (lock_low_seen) begin errors++; $display("FAIL nom_lock_held: got 1 expected 0"); end
  endtask

  task automatic test_saturate();
    int k0;
    logic [7:0] exp_s1, exp_s2;
    logic exp_t1, exp_t2;
`ifdef PWM_CAPTURE_VOLDIV_EN
    exp_s1 = 8'd255; exp_t1 = 1'b1; exp_s2 = 8'd0; exp_t2 = 1'b1;
`else
    exp_s1 = 8'd18; exp_t1 = 1'b0; exp_s2 = 8'd18; exp_t2 = 1'b0;
`endif
    do_reset();
    start_pwm(4'd1, 300, k0);
    run_until_valid(5000);
    vectors++; if (last_v_cyc != k0 + 4097 + LAT) begin errors++; $display("FAIL sat_valid_time: got %0d expected %0d", last_v_cyc, k0 + 4097 + LAT); end
    vectors++; if (last_sample !== exp_s1) begin errors++; $display("FAIL sat_sample_vol1: got %0d expected %0d", last_sample, exp_s1); end
    vectors++; if (last_sat !== exp_t1) begin errors++; $display("FAIL sat_flag_vol1: got %b expected %b", last_sat, exp_t1); end
    VOL = 4'd0;
    run_until_valid(5000);
    vectors++; if (last_v_cyc != k0 + 4096 + 4097 + LAT) begin errors++; $display("FAIL sat_valid_time_vol0: got %0d expected %0d", last_v_cyc, k0 + 4096 + 4097 + LAT); end
    vectors++; if (last_sample !== exp_s2) begin errors++; $display("FAIL sat_sample_vol0: got %0d expected %0d", last_sample, exp_s2); end
    vectors++; if (last_sat !== exp_t2) begin errors++; $display("FAIL sat_flag_vol0: got %b expected %b", last_sat, exp_t2); end
  endtask

  task automatic test_hunt();
    int k;
    logic exp_t;
`ifdef PWM_CAPTURE_VOLDIV_EN
    exp_t = 1'b1;
`else
    exp_t = 1'b0;
`endif
    do_reset();
    VOL = 4'd4;
    repeat (10000) tick();
    vectors++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL hunt_idle_lock: got %b expected 0", LOCKED); end
    vectors++; if (v_cnt != 0) begin errors++; $display("FAIL hunt_idle_valid: got %0d expected 0", v_cnt); end
    gen_mode = 1;
    tick();
    k = cyc;
    run_until_valid(5000);
    vectors++; if (last_v_cyc != k + 4097 + LAT) begin errors++; $display("FAIL hunt_valid_time: got %0d expected %0d", last_v_cyc, k + 4097 + LAT); end
    vectors++; if (last_sample !== 8'd255) begin errors++; $display("FAIL hunt_sample: got %0d expected 255", last_sample); end
    vectors++; if (last_sat !== exp_t) begin errors++; $display("FAIL hunt_sat: got %b expected %b", last_sat, exp_t); end
    while (cyc < k + 8193) tick();
    vectors++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL hunt_lock_before_end: got %b expected 1", LOCKED); end
    tick();
    vectors++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL hunt_lock_after_end: got %b expected 0", LOCKED); end
    repeat (20) tick();
    vectors++; if (v_cnt != 1) begin errors++; $display("FAIL hunt_valid_count: got %0d expected 1", v_cnt); end
  endtask

  task automatic test_glitch();
    int k0, k1, n;
    logic [7:0] exp_s;
`ifdef PWM_CAPTURE_VOLDIV_EN
    exp_s = 8'd100;
`else
    exp_s = 8'd25;
`endif
    do_reset();
    start_pwm(4'd4, 400, k0);
    n = 0;
    while (gen_pos != 2000 && n < 5000) begin tick(); n++; end
    lock_low_seen = 1'b0;
    gen_pos = 0;
    tick();
    k1 = frame_k;
    while (cyc < k0 + 4097 + LAT + 5) tick();
    vectors++; if (v_cnt != 0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected 0", v_cnt); end
    run_until_valid(5000);
    vectors++; if (last_v_cyc != k1 + 4097 + LAT) begin errors++; $display("FAIL glitch_valid_time: got %0d expected %0d", last_v_cyc, k1 + 4097 + LAT); end
    vectors++; if (last_sample !== exp_s) begin errors++; $display("FAIL glitch_sample: got %0d expected %0d", last_sample, exp_s); end
    vectors++; if (lock_low_seen) begin errors++; $display("FAIL glitch_lock_held: got 1 expected 0"); end
  endtask

  task automatic test_reset_mid();
    int k0, f_end, v_before, exp_v;
`ifdef PWM_CAPTURE_VOLDIV_EN
    exp_v = 1;
`else
    exp_v = 2;
`endif
    do_reset();
    start_pwm(4'd4, 400, k0);
    f_end = k0 + 8193;
    while (cyc < f_end + 5) tick();
    vectors++; if (v_cnt != exp_v) begin errors++; $display("FAIL rstmid_valid_before: got %0d expected %0d", v_cnt, exp_v); end
    RST = 1'b1;
    gen_mode = 0;
    tick();
    RST = 1'b0;
    vectors++; if (SAMPLE !== 8'd0) begin errors++; $display("FAIL rstmid_sample: got %0d expected 0", SAMPLE); end
    vectors++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rstmid_locked: got %b expected 0", LOCKED); end
    vectors++; if (VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", VALID); end
    v_before = v_cnt;
    repeat (30) tick();
    vectors++; if (v_cnt != v_before) begin errors++; $display("FAIL rstmid_aborted: got %0d expected %0d", v_cnt, v_before); end
  endtask

  task automatic test_no_div();
    int k0;
    logic [7:0] exp_s;
`ifdef PWM_CAPTURE_VOLDIV_EN
    exp_s = 8'd228;
`else
    exp_s = 8'd100;
`endif
    do_reset();
    start_pwm(4'd7, 1600, k0);
    run_until_valid(5000);
    vectors++; if (last_v_cyc != k0 + 4097 + LAT) begin errors++; $display("FAIL vol7_valid_time: got %0d expected %0d", last_v_cyc, k0 + 4097 + LAT); end
    vectors++; if (last_sample !== exp_s) begin errors++; $display("FAIL vol7_sample: got %0d expected %0d", last_sample, exp_s); end
    vectors++; if (last_sat !== 1'b0) begin errors++; $display("FAIL vol7_sat: got %b expected 0", last_sat); end
    tick();
    vectors++; if (VALID !== 1'b0) begin errors++; $display("FAIL vol7_pulse_width: got %b expected 0", VALID); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_saturate();
    test_hunt();
    test_glitch();
    test_reset_mid();
    test_no_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
